// File: rtl/video_mixer_pkg.sv
// Shared constants and layer-priority helpers for the video mixer.
package video_mixer_pkg;

  localparam int PAL_AW_DEF      = 9;
  localparam int SPR_HOLDOFF_DEF = 8;
  localparam int LATENCY_DEF     = 3;

  localparam logic [2:0] IDX_FG_PREFIX = 3'b110;
  localparam logic [1:0] IDX_SP_PREFIX = 2'b10;
  localparam logic       IDX_BG_PREFIX = 1'b0;

  typedef enum logic [1:0] {
    SRC_BG,
    SRC_SP,
    SRC_FG
  } pix_src_e;

  typedef logic [8:0] pal_idx_t;

  // Text always wins; a sprite beats the background if it has priority or the background is transparent.
  function automatic pix_src_e pick_source(input logic [7:0] sp, input logic [7:0] bg,
                                           input logic [5:0] fg, input logic spr_en);
    pix_src_e src;
    src = SRC_BG;
    if (fg[1:0] != 2'b00)
      src = SRC_FG;
    else if (spr_en && (sp[2:0] != 3'b000) && (sp[7] || (bg[3:0] == 4'h0)))
      src = SRC_SP;
    return src;
  endfunction

  function automatic pal_idx_t make_index(input pix_src_e src, input logic [7:0] sp,
                                          input logic [7:0] bg, input logic [5:0] fg);
    pal_idx_t idx;
    case (src)
      SRC_FG:  idx = {IDX_FG_PREFIX, fg};
      SRC_SP:  idx = {IDX_SP_PREFIX, sp[6:0]};
      default: idx = {IDX_BG_PREFIX, bg};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/video_mixer_if.sv
// Palette download bus between the loader (master) and the mixer (slave).
interface video_mixer_if;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        pal_r_cs;
  logic        pal_g_cs;
  logic        pal_b_cs;

  modport master (output dn_addr, dn_data, dn_wr, pal_r_cs, pal_g_cs, pal_b_cs);
  modport slave  (input  dn_addr, dn_data, dn_wr, pal_r_cs, pal_g_cs, pal_b_cs);
endinterface

// File: rtl/mixer_pal_rom.sv
// One downloadable palette channel with a registered read port.
// A write and a read of the same address on one edge returns the previous contents.
module mixer_pal_rom #(
  parameter int AW = 9,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_mixer.sv
// Three-layer pixel mixer: priority select into a downloadable palette, sprite
// holdoff after CPU sprite-RAM access, and a blank flag aligned with the colour.
module video_mixer
  import video_mixer_pkg::*;
#(
  parameter int PAL_AW      = PAL_AW_DEF,
  parameter int SPR_HOLDOFF = SPR_HOLDOFF_DEF,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic         master_clk,
  input  logic         nRESET,
  input  logic         pixel_ce,
  input  logic [7:0]   SP_PIX,
  input  logic [7:0]   BG_PIX,
  input  logic [5:0]   FG_PIX,
  input  logic         HBLANK,
  input  logic         VBLANK,
  input  logic         CPU_RAM_SELECT,
  video_mixer_if.slave dn,
  output logic [3:0]   RED,
  output logic [3:0]   GREEN,
  output logic [3:0]   BLUE,
  output logic         BLANK_OUT
);

  localparam logic [3:0] HOLD_LOAD = 4'(SPR_HOLDOFF);

  logic [3:0]         hold_cnt;
  logic               spr_en;
  logic [7:0]         s1_sp;
  logic [7:0]         s1_bg;
  logic [5:0]         s1_fg;
  logic               s1_spr_en;
  pal_idx_t           mix_idx;
  pal_idx_t           pal_idx;
  logic [LATENCY-1:0] blank_sr;
  logic [PAL_AW-1:0]  wr_addr;
  logic [PAL_AW-1:0]  rd_addr;
  logic [3:0]         rd_r;
  logic [3:0]         rd_g;
  logic [3:0]         rd_b;
  logic               unused_dn_bits;

  assign spr_en         = (hold_cnt == 4'd0) && !CPU_RAM_SELECT;
  assign mix_idx        = make_index(pick_source(s1_sp, s1_bg, s1_fg, s1_spr_en), s1_sp, s1_bg, s1_fg);
  assign wr_addr        = dn.dn_addr[PAL_AW-1:0];
  assign rd_addr        = PAL_AW'(pal_idx);
  assign unused_dn_bits = ^{dn.dn_addr[24:PAL_AW], dn.dn_data[7:4]};
  assign BLANK_OUT      = blank_sr[LATENCY-1];

  // Sprite RAM may be mid-update for a while after the CPU releases it, so sprites stay hidden.
  always_ff @(posedge master_clk or negedge nRESET) begin
    if (!nRESET)
      hold_cnt <= HOLD_LOAD;
    else if (pixel_ce) begin
      if (CPU_RAM_SELECT)
        hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 4'd1;
    end
  end

  always_ff @(posedge master_clk or negedge nRESET) begin
    if (!nRESET) begin
      s1_sp     <= '0;
      s1_bg     <= '0;
      s1_fg     <= '0;
      s1_spr_en <= 1'b0;
      pal_idx   <= '0;
    end else if (pixel_ce) begin
      s1_sp     <= SP_PIX;
      s1_bg     <= BG_PIX;
      s1_fg     <= FG_PIX;
      s1_spr_en <= spr_en;
      pal_idx   <= mix_idx;
    end
  end

  // The blank flag rides alongside the data so the colour is forced dark on the same pixel.
  always_ff @(posedge master_clk or negedge nRESET) begin
    if (!nRESET) begin
      blank_sr <= '1;
      RED      <= '0;
      GREEN    <= '0;
      BLUE     <= '0;
    end else if (pixel_ce) begin
      blank_sr <= {blank_sr[LATENCY-2:0], HBLANK | VBLANK};
      if (blank_sr[LATENCY-2]) begin
        RED   <= '0;
        GREEN <= '0;
        BLUE  <= '0;
      end else begin
        RED   <= rd_r;
        GREEN <= rd_g;
        BLUE  <= rd_b;
      end
    end
  end

  mixer_pal_rom #(.AW(PAL_AW), .DW(4)) u_pal_r (
    .clk   (master_clk),
    .we    (dn.dn_wr & dn.pal_r_cs),
    .waddr (wr_addr),
    .wdata (dn.dn_data[3:0]),
    .raddr (rd_addr),
    .rdata (rd_r)
  );

  mixer_pal_rom #(.AW(PAL_AW), .DW(4)) u_pal_g (
    .clk   (master_clk),
    .we    (dn.dn_wr & dn.pal_g_cs),
    .waddr (wr_addr),
    .wdata (dn.dn_data[3:0]),
    .raddr (rd_addr),
    .rdata (rd_g)
  );

  mixer_pal_rom #(.AW(PAL_AW), .DW(4)) u_pal_b (
    .clk   (master_clk),
    .we    (dn.dn_wr & dn.pal_b_cs),
    .waddr (wr_addr),
    .wdata (dn.dn_data[3:0]),
    .raddr (rd_addr),
    .rdata (rd_b)
  );

endmodule

// File: tb/tb_video_mixer.sv
// Bench for video_mixer: directed layer/holdoff/blank/download/reset cases and a
// random pixel stream compared against a behavioural model of the mixing rules.
module tb_video_mixer;

  localparam int HOLD = 8;

  typedef struct {
    logic blank;
    int   idx;
  } entry_t;

  typedef struct {
    logic       blank;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } colour_t;

  logic       master_clk = 1'b0;
  logic       nRESET;
  logic       pixel_ce;
  logic [7:0] SP_PIX;
  logic [7:0] BG_PIX;
  logic [5:0] FG_PIX;
  logic       HBLANK;
  logic       VBLANK;
  logic       CPU_RAM_SELECT;
  logic [3:0] RED;
  logic [3:0] GREEN;
  logic [3:0] BLUE;
  logic       BLANK_OUT;

  video_mixer_if dnbus ();

  video_mixer dut (
    .master_clk     (master_clk),
    .nRESET         (nRESET),
    .pixel_ce       (pixel_ce),
    .SP_PIX         (SP_PIX),
    .BG_PIX         (BG_PIX),
    .FG_PIX         (FG_PIX),
    .HBLANK         (HBLANK),
    .VBLANK         (VBLANK),
    .CPU_RAM_SELECT (CPU_RAM_SELECT),
    .dn             (dnbus),
    .RED            (RED),
    .GREEN          (GREEN),
    .BLUE           (BLUE),
    .BLANK_OUT      (BLANK_OUT)
  );

  always #5 master_clk = ~master_clk;

  logic [3:0] pal_r [512];
  logic [3:0] pal_g [512];
  logic [3:0] pal_b [512];

  int      total = 0;
  int      bad   = 0;
  int      rel_count;
  entry_t  stage_prev;
  colour_t pending;
  colour_t exp_out;

  logic       idle_wr;
  int         idle_ch;
  logic [8:0] idle_addr;
  logic [3:0] idle_data;

  function automatic colour_t resolve(input entry_t e);
    colour_t c;
    c.blank = e.blank;
    if (e.blank) begin
      c.r = 4'h0;
      c.g = 4'h0;
      c.b = 4'h0;
    end else begin
      c.r = pal_r[e.idx];
      c.g = pal_g[e.idx];
      c.b = pal_b[e.idx];
    end
    return c;
  endfunction

  task automatic modelReset();
    rel_count        = 0;
    stage_prev.blank = 1'b1;
    stage_prev.idx   = 0;
    pending.blank    = 1'b1;
    pending.r        = 4'h0;
    pending.g        = 4'h0;
    pending.b        = 4'h0;
    exp_out          = pending;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (BLANK_OUT === exp_out.blank) else begin
      bad++;
      $error("[TB] FAIL %s blank: got %b expected %b", tag, BLANK_OUT, exp_out.blank);
    end
    total++;
    assert (RED === exp_out.r) else begin
      bad++;
      $error("[TB] FAIL %s red: got %h expected %h", tag, RED, exp_out.r);
    end
    total++;
    assert (GREEN === exp_out.g) else begin
      bad++;
      $error("[TB] FAIL %s green: got %h expected %h", tag, GREEN, exp_out.g);
    end
    total++;
    assert (BLUE === exp_out.b) else begin
      bad++;
      $error("[TB] FAIL %s blue: got %h expected %h", tag, BLUE, exp_out.b);
    end
  endtask

  task automatic checkDirect(input string tag, input int idx);
    total++;
    assert (BLANK_OUT === 1'b0 && RED === pal_r[idx] && GREEN === pal_g[idx] && BLUE === pal_b[idx]) else begin
      bad++;
      $error("[TB] FAIL %s: got blank=%b rgb=%h%h%h expected blank=0 rgb=%h%h%h (index %h)",
             tag, BLANK_OUT, RED, GREEN, BLUE, pal_r[idx], pal_g[idx], pal_b[idx], idx);
    end
  endtask

  task automatic checkBlank(input string tag);
    total++;
    assert (BLANK_OUT === 1'b1 && RED === 4'h0 && GREEN === 4'h0 && BLUE === 4'h0) else begin
      bad++;
      $error("[TB] FAIL %s: got blank=%b rgb=%h%h%h expected blank=1 rgb=000", tag, BLANK_OUT, RED, GREEN, BLUE);
    end
  endtask

  task automatic driveDn(input int ch, input logic [8:0] addr, input logic [3:0] data);
    dnbus.dn_addr  = {16'($urandom), addr};
    dnbus.dn_data  = {4'($urandom), data};
    dnbus.dn_wr    = 1'b1;
    dnbus.pal_r_cs = (ch == 0);
    dnbus.pal_g_cs = (ch == 1);
    dnbus.pal_b_cs = (ch == 2);
  endtask

  task automatic releaseDn();
    dnbus.dn_wr    = 1'b0;
    dnbus.pal_r_cs = 1'b0;
    dnbus.pal_g_cs = 1'b0;
    dnbus.pal_b_cs = 1'b0;
  endtask

  task automatic modelWrite(input int ch, input logic [8:0] addr, input logic [3:0] data);
    if (ch == 0) pal_r[addr] = data;
    else if (ch == 1) pal_g[addr] = data;
    else pal_b[addr] = data;
  endtask

  task automatic dnWrite(input int ch, input logic [8:0] addr, input logic [3:0] data);
    pixel_ce = 1'b0;
    driveDn(ch, addr, data);
    @(posedge master_clk);
    #1;
    releaseDn();
    modelWrite(ch, addr, data);
  endtask

  // One pixel: a pixel_ce clock followed by an idle clock during which pixel inputs are scrambled.
  task automatic applyStimulus(input logic [7:0] sp, input logic [7:0] bg, input logic [5:0] fg,
                               input logic hb, input logic vb, input logic cpu, input string tag);
    entry_t e;
    logic   spr_ok;
    SP_PIX         = sp;
    BG_PIX         = bg;
    FG_PIX         = fg;
    HBLANK         = hb;
    VBLANK         = vb;
    CPU_RAM_SELECT = cpu;
    pixel_ce       = 1'b1;
    @(posedge master_clk);
    #1;
    if (cpu) begin
      spr_ok    = 1'b0;
      rel_count = 0;
    end else begin
      spr_ok = (rel_count >= HOLD);
      if (rel_count < 1000) rel_count++;
    end
    e.blank = hb | vb;
    if ((int'(fg) % 4) != 0)
      e.idx = 384 + int'(fg);
    else if (spr_ok && (int'(sp) % 8) != 0 && (int'(sp) >= 128 || (int'(bg) % 16) == 0))
      e.idx = 256 + (int'(sp) % 128);
    else
      e.idx = int'(bg);
    exp_out    = pending;
    pending    = resolve(stage_prev);
    stage_prev = e;
    checkOutput({tag, " ce"});

    pixel_ce = 1'b0;
    SP_PIX   = 8'($urandom);
    BG_PIX   = 8'($urandom);
    FG_PIX   = 6'($urandom);
    HBLANK   = 1'($urandom);
    if (idle_wr) driveDn(idle_ch, idle_addr, idle_data);
    @(posedge master_clk);
    #1;
    if (idle_wr) begin
      releaseDn();
      modelWrite(idle_ch, idle_addr, idle_data);
      idle_wr = 1'b0;
    end
    checkOutput({tag, " idle"});
  endtask

  initial begin
    nRESET         = 1'b0;
    pixel_ce       = 1'b0;
    SP_PIX         = '0;
    BG_PIX         = '0;
    FG_PIX         = '0;
    HBLANK         = 1'b0;
    VBLANK         = 1'b0;
    CPU_RAM_SELECT = 1'b0;
    dnbus.dn_addr  = '0;
    dnbus.dn_data  = '0;
    releaseDn();
    idle_wr   = 1'b0;
    idle_ch   = 0;
    idle_addr = '0;
    idle_data = '0;
    modelReset();

    repeat (3) @(posedge master_clk);
    #1;
    checkOutput("reset");
    nRESET = 1'b1;

    for (int a = 0; a < 512; a++)
      for (int ch = 0; ch < 3; ch++)
        dnWrite(ch, 9'(a), 4'($urandom));
    dnWrite(0, 9'h025, 4'h3);
    dnWrite(0, 9'h17F, 4'hC);
    dnWrite(0, 9'h185, 4'h9);
    dnWrite(0, 9'h101, 4'h6);
    dnWrite(0, 9'h031, 4'hE);
    dnWrite(0, 9'h03A, 4'h1);
    dnWrite(0, 9'h010, 4'h7);
    dnWrite(0, 9'h0FF, 4'h5);
    dnWrite(0, 9'h1FF, 4'hA);
    checkOutput("blank before first pixel");

    $display("[TB] sprite holdoff after CPU access");
    applyStimulus(8'hFF, 8'h25, 6'h00, 1'b0, 1'b0, 1'b1, "cpu owns ram");
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(8'hFF, 8'h25, 6'h00, 1'b0, 1'b0, 1'b0, "holdoff");
      if (k == 10) checkDirect("holdoff pixel 8 bg", 9'h025);
      if (k == 11) checkDirect("holdoff pixel 9 sprite", 9'h17F);
    end

    $display("[TB] layer priority");
    applyStimulus(8'h81, 8'h3A, 6'h05, 1'b0, 1'b0, 1'b0, "fg over sprite");
    applyStimulus(8'h00, 8'h10, 6'h00, 1'b0, 1'b0, 1'b0, "filler");
    applyStimulus(8'h00, 8'h10, 6'h00, 1'b0, 1'b0, 1'b0, "filler");
    checkDirect("fg index 185", 9'h185);
    applyStimulus(8'h01, 8'h30, 6'h00, 1'b0, 1'b0, 1'b0, "sprite on clear bg");
    applyStimulus(8'h01, 8'h31, 6'h00, 1'b0, 1'b0, 1'b0, "bg over low prio sprite");
    applyStimulus(8'h00, 8'h10, 6'h00, 1'b0, 1'b0, 1'b0, "filler");
    checkDirect("sprite index 101", 9'h101);
    applyStimulus(8'h00, 8'h10, 6'h00, 1'b0, 1'b0, 1'b0, "filler");
    checkDirect("bg index 031", 9'h031);

    $display("[TB] single blank pixel");
    applyStimulus(8'h00, 8'h10, 6'h00, 1'b0, 1'b0, 1'b0, "pre blank");
    applyStimulus(8'h00, 8'h3A, 6'h00, 1'b1, 1'b0, 1'b0, "hblank");
    applyStimulus(8'h00, 8'h3A, 6'h00, 1'b0, 1'b0, 1'b0, "post blank");
    checkDirect("pixel before blank", 9'h010);
    applyStimulus(8'h00, 8'h10, 6'h00, 1'b0, 1'b0, 1'b0, "filler");
    checkBlank("blank pixel");
    applyStimulus(8'h00, 8'h10, 6'h00, 1'b0, 1'b0, 1'b0, "filler");
    checkDirect("pixel after blank", 9'h03A);

    $display("[TB] download colliding with read");
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) begin
        idle_wr   = 1'b1;
        idle_ch   = 0;
        idle_addr = 9'h0FF;
        idle_data = 4'hA;
      end
      applyStimulus(8'h00, 8'hFF, 6'h00, 1'b0, 1'b0, 1'b0, "collision");
      if (k == 5) begin
        total++;
        assert (RED === 4'h5) else begin
          bad++;
          $error("[TB] FAIL collision old: got %h expected 5", RED);
        end
      end
      if (k == 6) begin
        total++;
        assert (RED === 4'hA) else begin
          bad++;
          $error("[TB] FAIL collision new: got %h expected a", RED);
        end
      end
    end

    $display("[TB] random pixel stream");
    for (int n = 0; n < 300; n++)
      applyStimulus(8'($urandom), 8'($urandom), 6'($urandom),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 19) == 0), "random");

    $display("[TB] reset mid-line");
    applyStimulus(8'h00, 8'h3A, 6'h00, 1'b0, 1'b0, 1'b0, "pre reset");
    nRESET = 1'b0;
    #2;
    checkBlank("async reset");
    @(posedge master_clk);
    #1;
    nRESET = 1'b1;
    modelReset();
    checkOutput("after reset release");
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(8'hFF, 8'h25, 6'h00, 1'b0, 1'b0, 1'b0, "post reset");
      if (k == 10) checkDirect("post reset pixel 8 bg", 9'h025);
      if (k == 11) checkDirect("post reset pixel 9 sprite", 9'h17F);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
